// File: rtl/video_capture_decimator.sv
// ---------------------------------------------------------------------------
// video_capture_decimator
//
// Captures a 24-bit RGB video stream, decimates it 2:1 in both directions
// (odd lines dropped, horizontal pixel pairs averaged), converts each pair to
// RGB444 and writes it into the 12-bit frame BRAM. With the default sizes the
// result is the 512x384 image the frame reader scans out.
//
// Ports
//   i_clk_pixel    pixel clock, all logic on its rising edge
//   i_rstn         asynchronous active-low reset
//   i_capture_en   1 = capture continuously, 0 = stop after the current frame
//   i_video_vde    active-video qualifier
//   i_video_hsync  line sync (registered only)
//   i_video_vsync  frame sync, active level VSYNC_POL
//   i_video_data   pixel R[23:16] G[15:8] B[7:0]
//   o_bram_we      write strobe, one cycle per output pixel
//   o_bram_addr    write address 0 .. (H/2)*(V/2)-1
//   o_bram_data    RGB444 {R,G,B}
//   o_busy         high while armed or capturing
//   o_frame_done   one-cycle pulse for each complete, correctly sized frame
//   o_frame_cnt    completed-frame count, wraps
//   o_err_size     sticky size error, cleared while i_capture_en = 0
//   o_dbg_state    FSM state register (0 idle, 1 arm, 2 capture)
//   o_dbg_hsync    registered hsync
//
// Handshake: there is no back-pressure. o_bram_we is a one-cycle strobe and
// o_bram_addr/o_bram_data are valid only in a cycle where it is high; the
// BRAM write port must accept every strobe.
// ---------------------------------------------------------------------------
module video_capture_decimator #(
    parameter logic [15:0] IMAGE_SIZE_H = 16'd1024,
    parameter logic [15:0] IMAGE_SIZE_V = 16'd768,
    parameter logic        VSYNC_POL    = 1'b1
) (
    input  logic        i_clk_pixel,
    input  logic        i_rstn,
    input  logic        i_capture_en,
    input  logic        i_video_vde,
    input  logic        i_video_hsync,
    input  logic        i_video_vsync,
    input  logic [23:0] i_video_data,
    output logic        o_bram_we,
    output logic [17:0] o_bram_addr,
    output logic [11:0] o_bram_data,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic [7:0]  o_frame_cnt,
    output logic        o_err_size,
    output logic [1:0]  o_dbg_state,
    output logic        o_dbg_hsync
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [17:0] HALF_H  = {3'b000, IMAGE_SIZE_H[15:1]};
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    state_t      state;

    // Stage 0: input registers
    logic        vde_r;
    logic        hs_r;
    logic        vs_r;
    logic [23:0] data_r;
    logic        vde_d;
    logic        vs_act_d;

    // Datapath state
    logic [10:0] pix_cnt;
    logic [10:0] line_cnt;
    logic [17:0] line_base;
    logic [23:0] even_r;

    // Combinational control
    logic        vs_act;
    logic        vs_lead;
    logic        vde_fall;
    logic        start;
    logic        in_cap;
    logic [10:0] cur_pix;
    logic [10:0] cur_line;
    logic [17:0] cur_base;
    logic        pix_over;
    logic        line_over;
    logic        pix_valid;
    logic        pair_write;
    logic        frame_end;
    logic        frame_ok;
    logic        size_err;
    logic [3:0]  r_avg;
    logic [3:0]  g_avg;
    logic [3:0]  b_avg;

    // vsync resets to its inactive level and the delayed "active" flag resets
    // high, so a sync already active at reset release is not taken as a new
    // frame start; the block waits for a real inactive->active transition.
    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) begin
            vde_r    <= 1'b0;
            hs_r     <= 1'b0;
            vs_r     <= ~VSYNC_POL;
            data_r   <= 24'd0;
            vde_d    <= 1'b0;
            vs_act_d <= 1'b1;
        end else begin
            vde_r    <= i_video_vde;
            hs_r     <= i_video_hsync;
            vs_r     <= i_video_vsync;
            data_r   <= i_video_data;
            vde_d    <= vde_r;
            vs_act_d <= vs_act;
        end
    end

    always_comb begin
        vs_act    = (vs_r == VSYNC_POL);
        vs_lead   = vs_act & ~vs_act_d;
        vde_fall  = vde_d & ~vde_r;
        frame_end = (state == ST_CAPTURE) & vs_lead;
        // A new frame starts on a sync edge from ARM, or from CAPTURE when
        // capture stays enabled.
        start     = vs_lead & i_capture_en &
                    ((state == ST_ARM) | (state == ST_CAPTURE));
        in_cap    = start | ((state == ST_CAPTURE) & ~vs_lead);
        // On a start cycle the counters are treated as already cleared, so a
        // pixel coinciding with the sync edge is pixel 0 of line 0.
        cur_pix   = start ? 11'd0 : pix_cnt;
        cur_line  = start ? 11'd0 : line_cnt;
        cur_base  = start ? 18'd0 : line_base;
        pix_over  = ({5'd0, cur_pix} >= IMAGE_SIZE_H);
        line_over = ({5'd0, cur_line} >= IMAGE_SIZE_V);
        pix_valid = in_cap & vde_r;
        pair_write = pix_valid & cur_pix[0] & ~cur_line[0] & ~pix_over & ~line_over;
        frame_ok  = frame_end & ({5'd0, line_cnt} == IMAGE_SIZE_V);
        size_err  = (pix_valid & (pix_over | line_over)) | (frame_end & ~frame_ok);
        // 9-bit channel sums; the top four bits are the truncated average.
        r_avg = 4'(({1'b0, even_r[23:16]} + {1'b0, data_r[23:16]}) >> 5);
        g_avg = 4'(({1'b0, even_r[15:8]}  + {1'b0, data_r[15:8]})  >> 5);
        b_avg = 4'(({1'b0, even_r[7:0]}   + {1'b0, data_r[7:0]})   >> 5);
    end

    // Control FSM with its registered status outputs.
    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= ST_IDLE;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_cnt  <= 8'd0;
            o_err_size   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_capture_en) begin
                        state  <= ST_ARM;
                        o_busy <= 1'b1;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                ST_ARM: begin
                    if (!i_capture_en) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        o_busy <= 1'b1;
                        if (vs_lead) begin
                            state <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    // A frame in progress always runs to its closing sync.
                    if (vs_lead && !i_capture_en) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end else begin
                        o_busy <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
            o_frame_done <= frame_ok;
            if (frame_ok) begin
                o_frame_cnt <= o_frame_cnt + 8'd1;
            end
            o_err_size <= i_capture_en ? (o_err_size | size_err) : 1'b0;
        end
    end

    // Counters, pair latch and BRAM write port.
    always_ff @(posedge i_clk_pixel or negedge i_rstn) begin
        if (!i_rstn) begin
            pix_cnt     <= 11'd0;
            line_cnt    <= 11'd0;
            line_base   <= 18'd0;
            even_r      <= 24'd0;
            o_bram_we   <= 1'b0;
            o_bram_addr <= 18'd0;
            o_bram_data <= 12'd0;
        end else begin
            if (start) begin
                pix_cnt   <= vde_r ? 11'd1 : 11'd0;
                line_cnt  <= 11'd0;
                line_base <= 18'd0;
            end else if (state == ST_CAPTURE) begin
                if (vde_r) begin
                    if (pix_cnt != CNT_MAX) begin
                        pix_cnt <= pix_cnt + 11'd1;
                    end
                end else if (vde_fall) begin
                    pix_cnt <= 11'd0;
                    if (line_cnt != CNT_MAX) begin
                        line_cnt <= line_cnt + 11'd1;
                    end
                    // The base advances by a full output line regardless of
                    // how many pixels this line had.
                    if (!line_cnt[0]) begin
                        line_base <= line_base + HALF_H;
                    end
                end
            end

            if (pix_valid && !cur_pix[0]) begin
                even_r <= data_r;
            end

            o_bram_we <= pair_write;
            if (pair_write) begin
                o_bram_addr <= cur_base + {8'd0, cur_pix[10:1]};
                o_bram_data <= {r_avg, g_avg, b_avg};
            end
        end
    end

    assign o_dbg_state = state;
    assign o_dbg_hsync = hs_r;

endmodule

// File: tb/tb_video_capture_decimator.sv
// ---------------------------------------------------------------------------
// Bench for video_capture_decimator with an 8x4 input image. A frame-level
// model decides from the stream it drives which BRAM writes (address, data
// and arrival cycle), done pulses, frame count and size error to expect.
// ---------------------------------------------------------------------------
module tb_video_capture_decimator;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0;
    logic        vde = 1'b0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic [23:0] din = 24'd0;

    logic        bram_we;
    logic [17:0] bram_addr;
    logic [11:0] bram_data;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        err_size;
    logic [1:0]  dbg_state;
    logic        dbg_hsync;

    video_capture_decimator #(
        .IMAGE_SIZE_H (16'(H)),
        .IMAGE_SIZE_V (16'(V)),
        .VSYNC_POL    (1'b1)
    ) dut (
        .i_clk_pixel   (clk),
        .i_rstn        (rstn),
        .i_capture_en  (en),
        .i_video_vde   (vde),
        .i_video_hsync (hs),
        .i_video_vsync (vs),
        .i_video_data  (din),
        .o_bram_we     (bram_we),
        .o_bram_addr   (bram_addr),
        .o_bram_data   (bram_data),
        .o_busy        (busy),
        .o_frame_done  (frame_done),
        .o_frame_cnt   (frame_cnt),
        .o_err_size    (err_size),
        .o_dbg_state   (dbg_state),
        .o_dbg_hsync   (dbg_hsync)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected write entry: {arrival cycle[15:0], addr[17:0], data[11:0]}
    logic [45:0] exp_q[$];
    bit          capturing = 1'b0;
    int          line_idx = 0;
    int          pix_idx = 0;
    logic [23:0] even_px = 24'd0;
    int          exp_cnt = 0;
    bit          exp_err = 1'b0;
    logic [23:0] line_px[0:15];

    function automatic logic [11:0] avg444(input logic [23:0] a, input logic [23:0] b);
        int r, g, bl;
        r  = (int'(a[23:16]) + int'(b[23:16])) / 32;
        g  = (int'(a[15:8])  + int'(b[15:8]))  / 32;
        bl = (int'(a[7:0])   + int'(b[7:0]))   / 32;
        return {4'(r), 4'(g), 4'(bl)};
    endfunction

    function automatic void model_pixel(input logic [23:0] px);
        int addr;
        if (!capturing) return;
        if (line_idx >= V || pix_idx >= H) begin
            if (en) exp_err = 1'b1;
        end else if (pix_idx % 2 == 0) begin
            even_px = px;
        end else if (line_idx % 2 == 0) begin
            addr = (line_idx / 2) * (H / 2) + pix_idx / 2;
            exp_q.push_back({16'(cyc + 2), 18'(addr), avg444(even_px, px)});
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rstn && bram_we) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", {46'd0, bram_addr}, 64'hFFFF_FFFF);
            end else begin
                check_val("bram_write", {16'(cyc), bram_addr, bram_data}, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_random();
        for (int i = 0; i < 16; i++) line_px[i] = 24'($urandom);
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vde = 1'b1;
            hs  = 1'b0;
            din = line_px[pix_idx % 16];
            model_pixel(din);
            pix_idx++;
        end
    endtask

    task automatic send_gap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vde = 1'b0;
            hs  = (i == 1);
            din = 24'($urandom);
        end
        if (pix_idx > 0 && capturing) line_idx++;
        pix_idx = 0;
    endtask

    task automatic send_line(input int n);
        send_pixels(n);
        send_gap(4);
    endtask

    task automatic set_en(input bit v);
        @(negedge clk);
        en = v;
        if (!v) exp_err = 1'b0;
    endtask

    // Frame sync: closes the running frame, checks the done pulse timing.
    task automatic send_vsync(input string tag);
        bit exp_done;
        exp_done = 1'b0;
        @(negedge clk);
        vde = 1'b0;
        vs  = 1'b1;
        if (capturing) begin
            if (line_idx == V) begin
                exp_done = 1'b1;
                exp_cnt  = (exp_cnt + 1) % 256;
            end else if (en) begin
                exp_err = 1'b1;
            end
        end
        capturing = en;
        line_idx  = 0;
        pix_idx   = 0;
        @(negedge clk);
        check_val({tag, "_done_early"}, 64'(frame_done), 64'd0);
        @(negedge clk);
        vs = 1'b0;
        check_val({tag, "_done"}, 64'(frame_done), 64'(exp_done));
        check_val({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_cnt));
        @(negedge clk);
        check_val({tag, "_done_width"}, 64'(frame_done), 64'd0);
        check_val({tag, "_err"}, 64'(err_size), 64'(exp_err));
        check_val({tag, "_busy"}, 64'(busy), 64'(en));
        send_gap(3);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_we"}, 64'(bram_we), 64'd0);
        check_val({tag, "_addr"}, 64'(bram_addr), 64'd0);
        check_val({tag, "_data"}, 64'(bram_data), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(frame_done), 64'd0);
        check_val({tag, "_cnt"}, 64'(frame_cnt), 64'd0);
        check_val({tag, "_err"}, 64'(err_size), 64'd0);
        check_val({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        fill_random();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rstn = 1'b1;
        send_gap(3);

        // Two full-white frames.
        set_en(1'b1);
        send_gap(3);
        check_val("armed_busy", 64'(busy), 64'd1);
        send_vsync("arm");
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) line_px[i] = 24'hFFFFFF;
            for (int l = 0; l < V; l++) send_line(H);
            send_vsync("white");
        end

        // Known averaging pairs, short first line, then full lines.
        fill_random();
        line_px[0] = 24'h100000;
        line_px[1] = 24'h300000;
        line_px[2] = 24'hF00000;
        line_px[3] = 24'hFF0000;
        send_line(6);
        fill_random();
        for (int l = 1; l < V; l++) send_line(H);
        check_val("short_line_err", 64'(err_size), 64'd0);
        send_vsync("pairs");

        // Overlong line: only H/2 writes, error set, frame still counted.
        fill_random();
        send_line(10);
        check_val("overlong_err", 64'(err_size), 64'd1);
        for (int l = 1; l < V; l++) send_line(H);
        send_vsync("overlong");

        // Too few lines: no done pulse.
        for (int l = 0; l < V - 1; l++) begin
            fill_random();
            send_line(H);
        end
        send_vsync("short_frame");

        // Disable mid-frame: frame completes, then idle with no writes.
        fill_random();
        send_line(H);
        send_line(H);
        set_en(1'b0);
        send_gap(2);
        check_val("err_cleared", 64'(err_size), 64'd0);
        check_val("busy_tail", 64'(busy), 64'd1);
        send_line(H);
        send_line(H);
        send_vsync("disable");
        send_line(H);
        send_vsync("idle");
        set_en(1'b1);
        send_line(H);
        check_val("rearm_busy", 64'(busy), 64'd1);
        send_vsync("rearm");

        // Random frames.
        for (int f = 0; f < 4; f++) begin
            int nl;
            nl = $urandom_range(V + 1, V - 1);
            for (int l = 0; l < nl; l++) begin
                fill_random();
                send_line($urandom_range(10, 4));
            end
            send_vsync("random");
        end

        // Reset mid-line.
        fill_random();
        send_pixels(5);
        #2 rstn = 1'b0;
        #1 check_reset_values("async_reset");
        exp_q.delete();
        capturing = 1'b0;
        line_idx  = 0;
        exp_cnt   = 0;
        exp_err   = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        send_pixels(3);
        send_gap(4);
        send_line(H);
        send_vsync("post_reset_arm");
        for (int l = 0; l < V; l++) begin
            fill_random();
            send_line(H);
        end
        send_vsync("post_reset");

        send_gap(8);
        check_val("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_capture_decimator.md
# video_capture_decimator

Frame-capture writer on the display side of the BRAM frame store. Accepts a 24-bit RGB video stream (vde/hsync/vsync) on `i_clk_pixel`, decimates it 2:1 horizontally and vertically, and converts it to RGB444. Writes the result into the 12-bit frame BRAM through its write port, producing the 512x384 image that the frame reader scans out. Acts as the writer counterpart of the BRAM read/scan-out path.

## Interface
- IMAGE_SIZE_H, 16'd1024, active pixels per input line; must be even.
- IMAGE_SIZE_V, 16'd768, active lines per input frame; must be even.
- VSYNC_POL, 1'b1, active level of `i_video_vsync`.
- i_clk_pixel  in  1  pixel clock; all logic on its rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_capture_en  in  1  level; 1 = capture frames continuously, 0 = stop after the current frame.
- i_video_vde  in  1  active-video qualifier.
- i_video_hsync  in  1  line sync; registered for completeness, not used for counting.
- i_video_vsync  in  1  frame sync, polarity per VSYNC_POL.
- i_video_data  in  24  pixel, R[23:16] G[15:8] B[7:0].
- o_bram_we  out  1  BRAM write strobe, one cycle per output pixel.
- o_bram_addr  out  18  BRAM write address, 0 .. (H/2)*(V/2)-1.
- o_bram_data  out  12  RGB444 {R[3:0],G[3:0],B[3:0]}.
- o_busy  out  1  high in ARM or CAPTURE.
- o_frame_done  out  1  one-cycle pulse when a complete, correctly sized frame has been written.
- o_frame_cnt  out  8  count of completed frames, wraps 255 -> 0.
- o_err_size  out  1  sticky size error; cleared while `i_capture_en` = 0.

## Operation
- Stage 0: all video inputs are registered once. `vs_act = (vsync_r == VSYNC_POL)`. Leading edge `vs_lead = vs_act & ~vs_act_d`.
- FSM states:
  - IDLE: entered from reset; goes to ARM when `i_capture_en` = 1.
  - ARM: waits for `vs_lead`, then goes to CAPTURE with counters cleared. Returns to IDLE if `i_capture_en` drops.
  - CAPTURE: active capture. On `vs_lead`, runs the frame check, then restarts (counters cleared) if `i_capture_en` = 1, else goes to IDLE.
- Disabling mid-frame never aborts; the frame in progress completes.
- pix_cnt (11b): increments on each `vde_r` cycle. Clears on the `vde_r` falling edge.
- line_cnt (11b): increments on each `vde_r` falling edge. Clears on frame start.
- Kept lines: `line_cnt[0]` = 0. Odd lines are discarded, with no write.
- Horizontal averaging on kept lines:
  - The even-index pixel (pix_cnt[0] = 0) is latched.
  - On the following odd pixel, each channel is summed as 9-bit `sum = a + b`; the output nibble is `sum[8:5]` (average, truncated to 4 bits).
  - A trailing unpaired even pixel is dropped.
- Address generation:
  - `o_bram_addr = line_base + pix_cnt[10:1]`.
  - `line_base` adds H/2 at the end of each kept line and clears at frame start.
  - No multiplier. Short lines do not shift later lines.
- Overlength suppression (set `o_err_size`):
  - pix_cnt ≥ IMAGE_SIZE_H: remaining pixels on that line are suppressed.
  - line_cnt ≥ IMAGE_SIZE_V: remaining lines are suppressed.
- Frame check at `vs_lead` in CAPTURE:
  - line_cnt == IMAGE_SIZE_V: pulse `o_frame_done`, increment `o_frame_cnt`.
  - Otherwise: set `o_err_size`; no done pulse, no count.
- `o_err_size` and `o_frame_cnt` hold across frames. `o_err_size` clears only while `i_capture_en` = 0.
- Writes occur only in CAPTURE.

## Timing
- Reset values: `o_bram_we`=0, `o_bram_addr`=0, `o_bram_data`=0, `o_busy`=0, `o_frame_done`=0, `o_frame_cnt`=0, `o_err_size`=0, FSM=IDLE, all counters 0.
- Reset is asynchronous and may assert mid-frame. After release, the block must re-arm and wait for a fresh `vs_lead`; it never resumes mid-frame.
- Write latency: `o_bram_we`/`o_bram_addr`/`o_bram_data` are registered and valid 2 cycles after the odd pixel is present on the inputs (input reg + output reg).
- `o_bram_we` is high for exactly 1 cycle per pixel pair. Back-to-back pairs give a write every 2nd cycle at most.
- `o_frame_done` pulses 1 cycle, 2 cycles after `vsync` reaches the active level at the input. `o_frame_cnt` updates in the same cycle.
- If `vde` and a `vs_lead` coincide: the frame check and restart happen first, and the pixel counts as pixel 0 of line 0 of the new frame.
- `o_busy` follows the FSM state register (registered, no combinational path from inputs).

## Test plan
- H=8, V=4, two frames of full-white pixels (0xFFFFFF) with `i_capture_en`=1 → 8 writes per frame, addresses 0..7, data 0xFFF. `o_frame_done` pulses twice, `o_frame_cnt`=2, `o_err_size`=0.
- Pixel pair R=0x10, R=0x30 (G, B = 0) → `sum`=0x040, output data 0x200. Pair 0xF0/0xFF → R nibble 0xF.
- Line 0 of 6 pixels, then 8-pixel lines (H=8) → line 0 yields addresses 0..2. Line 2 starts at address 4. `o_err_size`=0 until the frame check, then 1 only if the line count is short.
- 10-pixel line with H=8 → only 4 writes for that line, `o_err_size`=1. A frame with 3 lines and V=4 → no `o_frame_done` pulse, `o_err_size`=1.
- `i_capture_en` dropped mid-frame → the frame completes, done pulses, FSM goes to IDLE, and no further writes occur. Re-raising the enable → ARM waits for the next `vs_lead`.
- `i_rstn` asserted mid-line → all outputs go to reset values immediately. After release, no write occurs until the ARM→CAPTURE transition.
